// File: rtl/arm_pipe_pkg.sv
// Shared pipeline definitions used by the ID-stage hazard logic.
// A scoreboard entry mirrors the ID/EX register fields that matter for hazards.
package arm_pipe_pkg;

    localparam int REG_IDX_W = 4;

    typedef struct packed {
        logic                 wb;
        logic                 mem_r;
        logic [REG_IDX_W-1:0] dest;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

endpackage

// File: rtl/hazard_match.sv
// Compares one in-flight scoreboard entry against the decoding instruction's sources.
// load_use additionally qualifies the match with the entry being a load.
module hazard_match
    import arm_pipe_pkg::*;
(
    input  sb_entry_t            entry,
    input  logic [REG_IDX_W-1:0] src1,
    input  logic [REG_IDX_W-1:0] src2,
    input  logic                 use_src1,
    input  logic                 two_src,
    output logic                 match,
    output logic                 load_use
);

    always_comb begin
        match    = entry.wb && ((use_src1 && (src1 == entry.dest)) ||
                                (two_src  && (src2 == entry.dest)));
        load_use = match && entry.mem_r;
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: shadow scoreboard of EXE/MEM(/WB), stall and flush generation,
// and a saturating count of frozen cycles.
module id_hazard_ctrl
    import arm_pipe_pkg::*;
#(
    parameter int FWD_EN = 1,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_src1,
    input  logic [REG_IDX_W-1:0] id_src2,
    input  logic                 id_use_src1,
    input  logic                 id_two_src,
    input  logic                 id_wb_en,
    input  logic                 id_mem_r_en,
    input  logic [REG_IDX_W-1:0] id_dest,
    input  logic                 exe_b_taken,
    output logic                 freeze_if,
    output logic                 id_flush,
    output logic                 if_flush,
    output logic [CNT_W-1:0]     stall_cycles
);

    localparam logic [DEPTH-1:0] EXE_SLOT = DEPTH'(1);

    sb_entry_t        slot      [DEPTH];
    sb_entry_t        slot_next [DEPTH];
    logic [DEPTH-1:0] raw_match;
    logic [DEPTH-1:0] load_match;
    logic             hazard;
    logic             issue;

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        if (k == 0) begin : g_exe
            // A bubble here is exactly what the flushed ID/EX register will hold.
            assign slot_next[k] = issue ? '{wb: id_wb_en, mem_r: id_mem_r_en, dest: id_dest}
                                        : SB_BUBBLE;
        end else begin : g_shift
            assign slot_next[k] = slot[k-1];
        end

        hazard_match u_match (
            .entry    (slot[k]),
            .src1     (id_src1),
            .src2     (id_src2),
            .use_src1 (id_use_src1),
            .two_src  (id_two_src),
            .match    (raw_match[k]),
            .load_use (load_match[k])
        );
    end

    // With forwarding only a load sitting in EXE cannot be bypassed in time.
    assign hazard = id_valid && ((FWD_EN != 0) ? |(load_match & EXE_SLOT) : |raw_match);

    always_comb begin
        freeze_if = 1'b0;
        id_flush  = 1'b0;
        if_flush  = 1'b0;
        if (!reset) begin
            if (exe_b_taken) begin
                id_flush = 1'b1;
                if_flush = 1'b1;
            end else begin
                freeze_if = hazard;
                id_flush  = hazard;
            end
        end
    end

    assign issue = id_valid && !id_flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot <= '{default: SB_BUBBLE};
        end else begin
            slot <= slot_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (freeze_if && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Scoreboard bench: three builds (A: forwarding, B: no forwarding, C: no forwarding, 4-bit counter)
// share one stimulus stream; expectations are queued per cycle and checked at the falling edge.
module tb_id_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [3:0] id_src1;
    logic [3:0] id_src2;
    logic       id_use_src1;
    logic       id_two_src;
    logic       id_wb_en;
    logic       id_mem_r_en;
    logic [3:0] id_dest;
    logic       exe_b_taken;

    logic        fr_a, idf_a, iff_a;
    logic [3:0]  cnt_a;
    logic        fr_b, idf_b, iff_b;
    logic [15:0] cnt_b;
    logic        fr_c, idf_c, iff_c;
    logic [3:0]  cnt_c;

    id_hazard_ctrl #(.FWD_EN(1), .DEPTH(2), .CNT_W(4)) dut_a (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_two_src(id_two_src), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .id_dest(id_dest), .exe_b_taken(exe_b_taken),
        .freeze_if(fr_a), .id_flush(idf_a), .if_flush(iff_a), .stall_cycles(cnt_a)
    );

    id_hazard_ctrl #(.FWD_EN(0), .DEPTH(2), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_two_src(id_two_src), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .id_dest(id_dest), .exe_b_taken(exe_b_taken),
        .freeze_if(fr_b), .id_flush(idf_b), .if_flush(iff_b), .stall_cycles(cnt_b)
    );

    id_hazard_ctrl #(.FWD_EN(0), .DEPTH(2), .CNT_W(4)) dut_c (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_two_src(id_two_src), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .id_dest(id_dest), .exe_b_taken(exe_b_taken),
        .freeze_if(fr_c), .id_flush(idf_c), .if_flush(iff_c), .stall_cycles(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags = {freeze_if, id_flush, if_flush}
    typedef struct {
        string      name;
        int         dut;
        logic [2:0] flags;
        logic       chk_cnt;
        int         cnt;
    } exp_t;

    exp_t expq[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    localparam logic [2:0] NONE   = 3'b000;
    localparam logic [2:0] STALL  = 3'b110;
    localparam logic [2:0] BRANCH = 3'b011;

    task automatic push(input string n, input int d, input logic [2:0] f,
                        input logic cc, input int c);
        exp_t e;
        e.name = n; e.dut = d; e.flags = f; e.chk_cnt = cc; e.cnt = c;
        expq.push_back(e);
    endtask

    always @(negedge clk) begin
        while (expq.size() > 0) begin
            exp_t       e;
            logic [2:0] af;
            int         ac;
            e = expq.pop_front();
            case (e.dut)
                0:       begin af = {fr_a, idf_a, iff_a}; ac = int'(cnt_a); end
                1:       begin af = {fr_b, idf_b, iff_b}; ac = int'(cnt_b); end
                default: begin af = {fr_c, idf_c, iff_c}; ac = int'(cnt_c); end
            endcase
            total_cnt++;
            if (af === e.flags && (!e.chk_cnt || ac == e.cnt)) begin
                pass_cnt++;
            end else begin
                $display("FAIL %s dut%0d: flags(fr,idf,iff)=%b cnt=%0d, required flags=%b cnt=%0d%s",
                         e.name, e.dut, af, ac, e.flags, e.cnt, e.chk_cnt ? "" : " (cnt unchecked)");
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [3:0] s1, input logic u1,
                          input logic [3:0] s2, input logic two, input logic wb,
                          input logic mr, input logic [3:0] d, input logic bt);
        id_valid = v; id_src1 = s1; id_use_src1 = u1; id_src2 = s2; id_two_src = two;
        id_wb_en = wb; id_mem_r_en = mr; id_dest = d; exe_b_taken = bt;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reset with a hazard-looking vector and a taken branch present: outputs must stay low.
    task automatic do_reset(input string n);
        tick();
        reset = 1'b1;
        set_id(1, 3, 1, 3, 1, 1, 1, 3, 1);
        push({n, "_reset_a"}, 0, NONE, 1, 0);
        push({n, "_reset_b"}, 1, NONE, 1, 0);
        push({n, "_reset_c"}, 2, NONE, 1, 0);
        tick();
        reset = 1'b0;
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();

        // 1: load-use with forwarding stalls exactly one cycle
        do_reset("t1");
        tick(); set_id(1, 0, 0, 0, 0, 1, 1, 3, 0); push("t1_load_issue", 0, NONE, 1, 0);
        tick(); set_id(1, 3, 1, 0, 0, 1, 0, 4, 0); push("t1_load_use", 0, STALL, 1, 0);
        tick();                                    push("t1_reader_issue", 0, NONE, 1, 1);
        tick(); idle();                            push("t1_after", 0, NONE, 1, 1);

        // 2: ALU producer then consumer
        do_reset("t2");
        tick(); set_id(1, 0, 0, 0, 0, 1, 0, 3, 0); push("t2_add_issue", 0, NONE, 1, 0);
        tick(); set_id(1, 3, 1, 0, 0, 1, 0, 7, 0); push("t2_no_stall_fwd", 0, NONE, 1, 0);
                                                   push("t2_stall_nofwd", 1, STALL, 1, 0);
        tick(); idle();                            push("t2_after", 0, NONE, 1, 0);

        // 3: no forwarding, reader of R5 through src2 waits two cycles
        do_reset("t3");
        tick(); set_id(1, 0, 0, 0, 0, 1, 0, 5, 0); push("t3_add_issue", 1, NONE, 1, 0);
        tick(); set_id(1, 0, 0, 5, 1, 1, 0, 8, 0); push("t3_stall1", 1, STALL, 1, 0);
                                                   push("t3_fwd_no_stall", 0, NONE, 1, 0);
        tick();                                    push("t3_stall2", 1, STALL, 1, 1);
        tick();                                    push("t3_issue", 1, NONE, 1, 2);
        tick(); idle();                            push("t3_after", 1, NONE, 1, 2);

        // 4: reader of R6 after two independent instructions
        do_reset("t4");
        tick(); set_id(1, 0, 0, 0, 0, 1, 0, 6, 0);  push("t4_add", 1, NONE, 1, 0);
        tick(); set_id(1, 1, 1, 0, 0, 1, 0, 9, 0);  push("t4_x", 1, NONE, 1, 0);
        tick(); set_id(1, 2, 1, 0, 0, 1, 0, 10, 0); push("t4_y", 1, NONE, 1, 0);
        tick(); set_id(1, 6, 1, 0, 0, 1, 0, 11, 0); push("t4_no_stall", 1, NONE, 1, 0);

        // 5: taken branch beats a pending load-use hazard
        do_reset("t5");
        tick(); set_id(1, 0, 0, 0, 0, 1, 1, 3, 0); push("t5_load", 0, NONE, 1, 0);
        tick(); set_id(1, 3, 1, 0, 0, 1, 0, 4, 1); push("t5_branch_fwd", 0, BRANCH, 1, 0);
                                                   push("t5_branch_nofwd", 1, BRANCH, 1, 0);
        tick(); set_id(1, 3, 1, 0, 0, 1, 0, 4, 0); push("t5_slot0_bubble", 0, NONE, 1, 0);
                                                   push("t5_nofwd_mem_match", 1, STALL, 1, 0);
        tick(); idle();                            push("t5_after", 0, NONE, 1, 0);

        // 6: reset in the middle of a stall
        do_reset("t6");
        tick(); set_id(1, 0, 0, 0, 0, 1, 0, 5, 0); push("t6_add", 1, NONE, 1, 0);
        tick(); set_id(1, 5, 1, 0, 0, 1, 0, 8, 0); push("t6_stall", 1, STALL, 1, 0);
        tick(); reset = 1'b1;                      push("t6_reset_mid", 1, NONE, 1, 0);
                                                   push("t6_reset_mid_c", 2, NONE, 1, 0);
        tick(); reset = 1'b0;                      push("t6_reader_free", 1, NONE, 1, 0);
        tick(); idle();                            push("t6_after", 1, NONE, 1, 0);

        // 7: self-dependent reader of R5 held in ID: stall, stall, issue, ... 21 stalls in 32 cycles
        do_reset("t7");
        for (int c = 0; c < 32; c++) begin
            tick();
            set_id(1, 5, 1, 0, 0, 1, 0, 5, 0);
            push("t7_pattern", 2, (c % 3 == 0) ? NONE : STALL, 0, 0);
        end
        tick(); idle();
        push("t7_saturated", 2, NONE, 1, 15);
        push("t7_wide_count", 1, NONE, 1, 21);

        // 8: non-writing instruction with dest R2 creates no dependency
        do_reset("t8");
        tick(); set_id(1, 0, 0, 0, 0, 0, 1, 2, 0);  push("t8_nowb_issue", 1, NONE, 1, 0);
        tick(); set_id(1, 2, 1, 2, 1, 1, 0, 12, 0); push("t8_fwd", 0, NONE, 1, 0);
                                                    push("t8_nofwd", 1, NONE, 1, 0);
        tick(); idle();

        // 9: PC (R15) tracked like any other destination
        do_reset("t9");
        tick(); set_id(1, 0, 0, 0, 0, 1, 0, 15, 0); push("t9_add_pc", 1, NONE, 1, 0);
        tick(); set_id(1, 0, 0, 15, 1, 1, 0, 1, 0); push("t9_stall1", 1, STALL, 1, 0);
        tick();                                     push("t9_stall2", 1, STALL, 1, 1);
        tick(); idle();

        tick();
        tick();
        total_cnt++;
        if (expq.size() == 0) pass_cnt++;
        else $display("FAIL queue_drain: %0d entries left, required 0", expq.size());

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required finish before it");
        $fatal(1);
    end

endmodule
